// File: rtl/sig_condition.sv
// Input conditioning for the frequency meter: synchronises and deglitches
// fx/fxB, emits single-cycle edge strobes, flags loss of signal per channel
// and counts rejected glitches across both channels.

// One conditioned channel: sync chain, run-length filter, output stage, loss timer.
module sig_cond_chan #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int TIMEOUT     = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o,
   output logic lost_o,
   output logic glitch_o
);
   localparam int RW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [RW-1:0] RMAX = RW'(FILT_LEN - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   lvl_q, lvl_d;
   logic [RW-1:0]          run_q, run_d;
   logic                   glitch;
   logic                   out_q, rise_q, fall_q;
   logic                   rise_d, fall_d;
   logic [TW-1:0]          t_q, t_d;
   logic                   lost_q;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain; only the last stage feeds the filter.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   // Filter decision: accept after FILT_LEN disagreeing samples, a short run is a glitch.
   always_comb begin
      lvl_d  = lvl_q;
      run_d  = run_q;
      glitch = 1'b0;
      if (s != lvl_q) begin
         if (run_q == RMAX) begin
            lvl_d = s;
            run_d = '0;
         end else begin
            run_d = run_q + 1'b1;
         end
      end else if (run_q != '0) begin
         run_d  = '0;
         glitch = 1'b1;
      end
   end

   // Filter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q <= 1'b0;
         run_q <= '0;
      end else begin
         lvl_q <= lvl_d;
         run_q <= run_d;
      end
   end

   // Strobes come from the output register lagging the accepted level; the
   // loss timer restarts on either strobe and saturates at TIMEOUT.
   always_comb begin
      rise_d = lvl_q & ~out_q;
      fall_d = ~lvl_q & out_q;
      if (rise_d | fall_d)  t_d = '0;
      else if (t_q == TMAX) t_d = t_q;
      else                  t_d = t_q + 1'b1;
   end

   // Output stage and loss timer; lost clears in the same cycle as the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         t_q    <= '0;
         lost_q <= 1'b0;
      end else begin
         out_q  <= lvl_q;
         rise_q <= rise_d;
         fall_q <= fall_d;
         t_q    <= t_d;
         lost_q <= (t_d == TMAX);
      end
   end

   assign lvl_o    = out_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign lost_o   = lost_q;
   assign glitch_o = glitch;
endmodule

// Top: two independent channels sharing one saturating glitch counter.
module sig_condition #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int TIMEOUT     = 50_000_000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fx_in,
   input  logic             fxB_in,
   input  logic             glitch_clr,
   output logic             fx_out,
   output logic             fxB_out,
   output logic             fx_rise,
   output logic             fx_fall,
   output logic             fxB_rise,
   output logic             fxB_fall,
   output logic             fx_lost,
   output logic             fxB_lost,
   output logic [CNT_W-1:0] glitch_cnt
);
   localparam logic [CNT_W:0] CMAX = {1'b0, {CNT_W{1'b1}}};

   logic [1:0]       pin, lvl, rise, fall, lost, glitch;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;

   assign pin = {fxB_in, fx_in};

   sig_cond_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_chan [1:0] (
      .clk     (clk),
      .rst     (rst),
      .pin_i   (pin),
      .lvl_o   (lvl),
      .rise_o  (rise),
      .fall_o  (fall),
      .lost_o  (lost),
      .glitch_o(glitch)
   );

   // Glitch count next value: clear wins, otherwise add 0..2 and clamp at all-ones.
   always_comb begin
      sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, glitch[0]} + {{CNT_W{1'b0}}, glitch[1]};
      if (glitch_clr)      cnt_d = '0;
      else if (sum > CMAX) cnt_d = '1;
      else                 cnt_d = sum[CNT_W-1:0];
   end

   // Glitch counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign fx_out     = lvl[0];
   assign fxB_out    = lvl[1];
   assign fx_rise    = rise[0];
   assign fx_fall    = fall[0];
   assign fxB_rise   = rise[1];
   assign fxB_fall   = fall[1];
   assign fx_lost    = lost[0];
   assign fxB_lost   = lost[1];
   assign glitch_cnt = cnt_q;
endmodule

// File: tb/tb_sig_condition.sv
// Directed bench for sig_condition: a per-cycle vector table plus hand-written
// sequences for reset-in-flight, reset release with pin high, loss timeout
// and glitch counter saturation.
module tb_sig_condition;
   logic clk = 1'b0;
   logic rst, fx_in, fxB_in, glitch_clr;

   // dut: FILT_LEN=3, short timeout, 4-bit counter
   logic       fx_out, fxB_out, fx_rise, fx_fall, fxB_rise, fxB_fall, fx_lost, fxB_lost;
   logic [3:0] glitch_cnt;
   // dut1: FILT_LEN=1 on the same pins
   logic        f1_out, f1b_out, f1_rise, f1_fall, f1b_rise, f1b_fall, f1_lost, f1b_lost;
   logic [15:0] f1_cnt;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   sig_condition #(.SYNC_STAGES(2), .FILT_LEN(3), .TIMEOUT(100), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .fx_in(fx_in), .fxB_in(fxB_in), .glitch_clr(glitch_clr),
      .fx_out(fx_out), .fxB_out(fxB_out), .fx_rise(fx_rise), .fx_fall(fx_fall),
      .fxB_rise(fxB_rise), .fxB_fall(fxB_fall), .fx_lost(fx_lost), .fxB_lost(fxB_lost),
      .glitch_cnt(glitch_cnt)
   );

   sig_condition #(.SYNC_STAGES(2), .FILT_LEN(1), .TIMEOUT(100), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .fx_in(fx_in), .fxB_in(fxB_in), .glitch_clr(glitch_clr),
      .fx_out(f1_out), .fxB_out(f1b_out), .fx_rise(f1_rise), .fx_fall(f1_fall),
      .fxB_rise(f1b_rise), .fxB_fall(f1b_fall), .fx_lost(f1_lost), .fxB_lost(f1b_lost),
      .glitch_cnt(f1_cnt)
   );

   // flags: [7]fx_out [6]fxB_out [5]fx_rise [4]fx_fall [3]fxB_rise [2]fxB_fall [1]fx_lost [0]fxB_lost
   typedef struct packed {
      logic       rst;
      logic       fx;
      logic       fxb;
      logic       clr;
      logic [7:0] eflags;
      logic [3:0] ecnt;
      logic       eout1;
   } vec_t;

   localparam int NV = 34;
   vec_t v [NV];

   function automatic logic [7:0] flags();
      return {fx_out, fxB_out, fx_rise, fx_fall, fxB_rise, fxB_fall, fx_lost, fxB_lost};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Drive inputs, let one posedge sample them, settle just after the edge.
   task automatic cyc(input logic r, input logic a, input logic b, input logic c);
      rst = r; fx_in = a; fxB_in = b; glitch_clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic glitch_fx();
      repeat (2) cyc(0, 1, 0, 0);
      repeat (4) cyc(0, 0, 0, 0);
   endtask

   task automatic glitch_both();
      repeat (2) cyc(0, 1, 1, 0);
      repeat (4) cyc(0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  n;
      logic bad;
      // Entry i: inputs sampled at edge i, expected outputs right after edge i.
      for (int i = 0; i < NV; i++) v[i] = '0;
      v[0].rst = 1'b1;
      for (int i = 1; i <= 7; i++) v[i].fx  = 1'b1;   // fx step up at 1, down at 8
      for (int i = 3; i <= 9; i++) v[i].fxb = 1'b1;   // fxB step up at 3, down at 10
      v[15].fx = 1'b1; v[16].fx = 1'b1;               // 2-sample fx glitch
      v[21].fx = 1'b1; v[22].fx = 1'b1; v[21].fxb = 1'b1; v[22].fxb = 1'b1;
      v[27].fx = 1'b1; v[28].fx = 1'b1; v[27].fxb = 1'b1; v[28].fxb = 1'b1;
      v[31].clr = 1'b1;                                // lands on the dual glitch event
      for (int i = 6; i <= 12; i++) v[i].eflags[7] = 1'b1;
      v[6].eflags[5]  = 1'b1;
      v[13].eflags[4] = 1'b1;
      for (int i = 8; i <= 14; i++) v[i].eflags[6] = 1'b1;
      v[8].eflags[3]  = 1'b1;
      v[15].eflags[2] = 1'b1;
      for (int i = 19; i <= 24; i++) v[i].ecnt = 4'd1;
      for (int i = 25; i <= 30; i++) v[i].ecnt = 4'd3;
      for (int i = 4; i <= 10; i++) v[i].eout1 = 1'b1;
      v[18].eout1 = 1'b1; v[19].eout1 = 1'b1;
      v[24].eout1 = 1'b1; v[25].eout1 = 1'b1;
      v[30].eout1 = 1'b1; v[31].eout1 = 1'b1;

      rst = 1'b1; fx_in = 1'b0; fxB_in = 1'b0; glitch_clr = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         cyc(v[i].rst, v[i].fx, v[i].fxb, v[i].clr);
         chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(v[i].eflags));
         chk($sformatf("vec%0d_cnt", i), 32'(glitch_cnt), 32'(v[i].ecnt));
         chk($sformatf("vec%0d_f1", i), {15'd0, f1_cnt, f1_out}, {31'd0, v[i].eout1});
      end

      // Reset while the fx run counter sits at 2: nothing leaks out afterwards.
      repeat (4) cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("rst_mid_flags", 32'(flags()), 32'd0);
      chk("rst_mid_cnt", 32'(glitch_cnt), 32'd0);
      bad = 1'b0;
      repeat (8) begin
         cyc(0, 0, 0, 0);
         if (fx_rise || fx_out || glitch_cnt != 4'd0) bad = 1'b1;
      end
      chk("rst_mid_quiet", 32'(bad), 32'd0);

      // Pin already high at reset release: rise on the 6th cycle after the reset edge.
      cyc(1, 1, 0, 0);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc(0, 1, 0, 0);
         if (fx_rise) begin n = k; break; end
      end
      chk("rel_high_lat", n, 6);
      chk("rel_high_out", 32'(fx_out), 32'd1);
      cyc(0, 1, 0, 0);
      chk("rel_high_once", {fx_rise, fx_fall, fx_out}, 3'b001);

      // Loss detect: static inputs, lost exactly TIMEOUT cycles after reset.
      cyc(1, 0, 0, 0);
      repeat (99) cyc(0, 0, 0, 0);
      chk("lost_99", {fx_lost, fxB_lost}, 2'b00);
      cyc(0, 0, 0, 0);
      chk("lost_100", {fx_lost, fxB_lost}, 2'b11);
      repeat (5) cyc(0, 1, 0, 0);
      chk("lost_hold", {fx_rise, fx_lost, fxB_lost}, 3'b011);
      cyc(0, 1, 0, 0);
      chk("lost_drop", {fx_rise, fx_lost, fxB_lost}, 3'b101);
      cyc(0, 1, 0, 0);
      chk("lost_after", {fx_rise, fx_lost, fxB_lost}, 3'b001);

      // Counter saturation with 4-bit width.
      repeat (8) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("sat_clr", 32'(glitch_cnt), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         glitch_fx();
         chk($sformatf("sat_g%0d", k), 32'(glitch_cnt), (k > 15) ? 32'd15 : 32'(k));
      end
      cyc(0, 0, 0, 1);
      repeat (14) glitch_fx();
      chk("sat_14", 32'(glitch_cnt), 32'd14);
      glitch_both();
      chk("sat_14_plus2", 32'(glitch_cnt), 32'd15);
      glitch_both();
      chk("sat_15_plus2", 32'(glitch_cnt), 32'd15);
      chk("f1_no_glitch", 32'(f1_cnt), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
